// File: rtl/aes_dec_arbiter.sv
// Round-robin front end that shares one pipelined AES inverse-cipher datapath among NUM_REQ requesters.
// Optional protocol checking (sticky err plus assertion) is enabled by defining AES_DEC_ARB_CHECK_EN.
module aes_dec_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int IDW        = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*128-1:0] req_ct,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   cipher_load,
    output logic [127:0]           cipher_ct,
    input  logic                   cipher_valid,
    input  logic [127:0]           cipher_pt,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [127:0]           rsp_pt,
    output logic [IDW-1:0]         rsp_id,
    output logic                   err
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [IDW-1:0] ptr;
    logic [CW-1:0]  credits;
    logic [IDW-1:0] win;
    logic           found;
    logic           grant;

    logic [IDW-1:0] id_mem [FIFO_DEPTH];
    logic [AW:0]    id_wp, id_rp;
    logic           id_empty;
    logic           id_pop;

    logic [127:0]   res_pt_mem [FIFO_DEPTH];
    logic [IDW-1:0] res_id_mem [FIFO_DEPTH];
    logic [AW:0]    res_wp, res_rp;
    logic           res_empty, res_full;
    logic           res_write, res_pop;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[(int'(ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = IDW'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    // The registered credit count gates the grant, so a pop frees a slot only from the next cycle on.
    assign grant     = found && (credits < CW'(FIFO_DEPTH));
    assign req_ready = grant ? (NUM_REQ'(1) << win) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= IDW'(NUM_REQ - 1);
            cipher_load <= 1'b0;
            cipher_ct   <= '0;
        end else begin
            cipher_load <= grant;
            if (grant) begin
                ptr       <= win;
                cipher_ct <= req_ct[128*win +: 128];
            end
        end
    end

    // Owner of each in-flight block, in pipeline order.
    assign id_empty = (id_wp == id_rp);
    assign id_pop   = cipher_valid && !id_empty;

    always_ff @(posedge clk) begin
        if (grant) begin
            id_mem[id_wp[AW-1:0]] <= win;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_wp <= '0;
            id_rp <= '0;
        end else begin
            if (grant) begin
                id_wp <= id_wp + (AW+1)'(1);
            end
            if (id_pop) begin
                id_rp <= id_rp + (AW+1)'(1);
            end
        end
    end

    // Results with no owner, or arriving into a full FIFO, are dropped.
    assign res_empty = (res_wp == res_rp);
    assign res_full  = (res_wp[AW] != res_rp[AW]) && (res_wp[AW-1:0] == res_rp[AW-1:0]);
    assign res_write = cipher_valid && !id_empty && !res_full;
    assign res_pop   = rsp_valid && rsp_ready;

    assign rsp_valid = !res_empty;
    assign rsp_pt    = res_pt_mem[res_rp[AW-1:0]];
    assign rsp_id    = res_id_mem[res_rp[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_wp <= '0;
            res_rp <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                res_pt_mem[i] <= '0;
                res_id_mem[i] <= '0;
            end
        end else begin
            if (res_write) begin
                res_pt_mem[res_wp[AW-1:0]] <= cipher_pt;
                res_id_mem[res_wp[AW-1:0]] <= id_mem[id_rp[AW-1:0]];
                res_wp                     <= res_wp + (AW+1)'(1);
            end
            if (res_pop) begin
                res_rp <= res_rp + (AW+1)'(1);
            end
        end
    end

    // Credits cover a block from issue until its result leaves the result FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits <= '0;
        end else if (grant && !res_pop) begin
            credits <= credits + CW'(1);
        end else if (!grant && res_pop) begin
            credits <= credits - CW'(1);
        end
    end

`ifdef AES_DEC_ARB_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (cipher_valid && (id_empty || res_full)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;

`ifndef SYNTHESIS
    assert property (@(posedge clk) disable iff (rst) !(cipher_valid && (id_empty || res_full)))
        else $error("aes_dec_arbiter: pipeline result with no owner or into a full result FIFO");
`endif
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_dec_arbiter.sv
// Scoreboard bench for aes_dec_arbiter with an 11-stage stand-in for the AES inverse-cipher pipeline.
module tb_aes_dec_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int IDW        = 2;
    localparam int LAT        = 11;

    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

    logic                   clk;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*128-1:0] req_ct;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   cipher_load;
    logic [127:0]           cipher_ct;
    logic                   cipher_valid;
    logic [127:0]           cipher_pt;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [127:0]           rsp_pt;
    logic [IDW-1:0]         rsp_id;
    logic                   err;
    logic                   inject;

    aes_dec_arbiter #(.NUM_REQ(NUM_REQ), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ct       (req_ct),
        .req_ready    (req_ready),
        .cipher_load  (cipher_load),
        .cipher_ct    (cipher_ct),
        .cipher_valid (cipher_valid),
        .cipher_pt    (cipher_pt),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_pt       (rsp_pt),
        .rsp_id       (rsp_id),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in decryptor: the FIPS-197 vector decrypts correctly, anything else gets a fixed scramble.
    function automatic logic [127:0] pipe_f(input logic [127:0] ct);
        if (ct == FIPS_CT) return FIPS_PT;
        return {ct[63:0], ct[127:64]} ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969;
    endfunction

    logic [LAT-1:0] pv;
    logic [127:0]   pd [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pv <= '0;
        else     pv <= {pv[LAT-2:0], cipher_load};
    end

    always_ff @(posedge clk) begin
        pd[0] <= pipe_f(cipher_ct);
        for (int k = 1; k < LAT; k++) pd[k] <= pd[k-1];
    end

    assign cipher_valid = pv[LAT-1] | inject;
    assign cipher_pt    = pd[LAT-1];

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [127:0]   pt;
    } exp_t;

    exp_t         sb [$];
    int           grant_log [$];
    int           checks = 0;
    int           errors = 0;
    int           ptr_m, credits_m, cyc, dut_grants, rsp_count;
    int           load_cyc, cv_cyc, rv_cyc;
    bit           prev_grant, stalled;
    logic [127:0] prev_ct, held_pt;
    logic [IDW-1:0] held_id;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic randomizeCt();
        for (int i = 0; i < NUM_REQ; i++)
            req_ct[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // One clock cycle: compare against the reference model at negedge, then advance to just past posedge.
    task automatic applyStimulus();
        int win;
        int idx;
        bit g;
        logic [NUM_REQ-1:0] exp_ready;
        @(negedge clk);
        win = -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (ptr_m + k) % NUM_REQ;
            if (win < 0 && req_valid[idx]) win = idx;
        end
        g = (win >= 0) && (credits_m < FIFO_DEPTH);
        exp_ready = g ? NUM_REQ'(1) << win : '0;
        checkOutput("req_ready", 128'(req_ready), 128'(exp_ready));
        checkOutput("cipher_load", 128'(cipher_load), 128'(prev_grant));
        if (prev_grant) checkOutput("cipher_ct", cipher_ct, prev_ct);
        if (|(req_valid & req_ready)) dut_grants++;
        if (cipher_load && load_cyc < 0) load_cyc = cyc;
        if (cipher_valid && cv_cyc < 0) cv_cyc = cyc;
        if (rsp_valid && rv_cyc < 0) rv_cyc = cyc;
        if (stalled) begin
            checkOutput("hold_valid", 128'(rsp_valid), 128'd1);
            checkOutput("hold_pt", rsp_pt, held_pt);
            checkOutput("hold_id", 128'(rsp_id), 128'(held_id));
        end
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                checkOutput("rsp_unexpected", 128'(rsp_valid), 128'd0);
            end else begin
                checkOutput("rsp_id", 128'(rsp_id), 128'(sb[0].id));
                checkOutput("rsp_pt", rsp_pt, sb[0].pt);
            end
        end
        stalled = rsp_valid && !rsp_ready;
        held_pt = rsp_pt;
        held_id = rsp_id;
        if (rsp_valid && rsp_ready) begin
            if (sb.size() > 0) void'(sb.pop_front());
            credits_m--;
            rsp_count++;
        end
        if (g) begin
            prev_ct = req_ct[win*128 +: 128];
            sb.push_back({IDW'(win), pipe_f(prev_ct)});
            ptr_m = win;
            credits_m++;
            grant_log.push_back(win);
        end
        prev_grant = g;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic applyReset();
        req_valid = '0;
        rsp_ready = 1'b1;
        inject    = 1'b0;
        rst       = 1'b1;
        #2;
        checkOutput("rst_req_ready", 128'(req_ready), 128'd0);
        checkOutput("rst_cipher_load", 128'(cipher_load), 128'd0);
        checkOutput("rst_cipher_ct", cipher_ct, 128'd0);
        checkOutput("rst_rsp_valid", 128'(rsp_valid), 128'd0);
        checkOutput("rst_rsp_pt", rsp_pt, 128'd0);
        checkOutput("rst_rsp_id", 128'(rsp_id), 128'd0);
        checkOutput("rst_err", 128'(err), 128'd0);
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b0;
        ptr_m      = NUM_REQ - 1;
        credits_m  = 0;
        sb.delete();
        grant_log.delete();
        prev_grant = 1'b0;
        stalled    = 1'b0;
        cyc        = 0;
        dut_grants = 0;
        rsp_count  = 0;
        load_cyc   = -1;
        cv_cyc     = -1;
        rv_cyc     = -1;
    endtask

    initial begin
        int base;
        int budget;
        rst       = 1'b0;
        req_valid = '0;
        req_ct    = '0;
        rsp_ready = 1'b1;
        inject    = 1'b0;
        #1;

        // Single FIFS-197 block from requester 2, with exact cycle timing.
        applyReset();
        req_ct[2*128 +: 128] = FIPS_CT;
        req_valid = 4'b0100;
        applyStimulus();
        req_valid = '0;
        repeat (20) applyStimulus();
        checkOutput("single_load_cyc", 128'(load_cyc), 128'd1);
        checkOutput("single_valid_cyc", 128'(cv_cyc), 128'd12);
        checkOutput("single_rsp_cyc", 128'(rv_cyc), 128'd13);
        checkOutput("single_rsp_count", 128'(rsp_count), 128'd1);

        // Round-robin with everyone requesting from reset.
        applyReset();
        req_valid = 4'hf;
        for (int i = 0; i < 8; i++) begin
            randomizeCt();
            applyStimulus();
        end
        req_valid = '0;
        repeat (20) applyStimulus();
        for (int i = 0; i < 8; i++) checkOutput("rr_order", 128'(grant_log[i]), 128'(i % NUM_REQ));
        checkOutput("rr_rsp_count", 128'(rsp_count), 128'd8);

        // Credit stall: no consumer, so exactly FIFO_DEPTH grants, then one more per popped entry.
        applyReset();
        rsp_ready = 1'b0;
        req_valid = 4'hf;
        randomizeCt();
        repeat (30) applyStimulus();
        checkOutput("stall_grants", 128'(dut_grants), 128'(FIFO_DEPTH));
        rsp_ready = 1'b1;
        applyStimulus();
        rsp_ready = 1'b0;
        base = dut_grants;
        repeat (15) applyStimulus();
        checkOutput("stall_one_more", 128'(dut_grants - base), 128'd1);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (40) applyStimulus();
        checkOutput("stall_rsp_count", 128'(rsp_count), 128'(FIFO_DEPTH + 1));

        // Random back-pressure over 40 blocks.
        applyReset();
        budget = 0;
        while (grant_log.size() < 40 && budget < 2000) begin
            req_valid = NUM_REQ'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 2) == 0);
            randomizeCt();
            applyStimulus();
            budget++;
        end
        req_valid = '0;
        budget = 0;
        while ((sb.size() != 0 || cv_cyc < 0) && budget < 1000) begin
            rsp_ready = ($urandom_range(0, 2) == 0);
            applyStimulus();
            budget++;
        end
        rsp_ready = 1'b1;
        repeat (15) applyStimulus();
        checkOutput("bp_grants", 128'(grant_log.size()), 128'd40);
        checkOutput("bp_rsp_count", 128'(rsp_count), 128'd40);

        // Reset while three blocks are in flight.
        applyReset();
        req_valid = 4'hf;
        randomizeCt();
        repeat (3) applyStimulus();
        req_valid = '0;
        repeat (5) applyStimulus();
        applyReset();
        repeat (20) applyStimulus();
        checkOutput("mid_rst_no_rsp", 128'(rsp_count), 128'd0);
        req_valid = 4'b1000;
        randomizeCt();
        applyStimulus();
        req_valid = '0;
        repeat (16) applyStimulus();
        checkOutput("mid_rst_new_rsp", 128'(rsp_count), 128'd1);
        checkOutput("mid_rst_new_id", 128'(grant_log[0]), 128'd3);

        // Orphan result from the pipeline with nothing outstanding.
        applyReset();
        inject = 1'b1;
        applyStimulus();
        inject = 1'b0;
        repeat (4) applyStimulus();
`ifdef AES_DEC_ARB_CHECK_EN
        checkOutput("err_sticky", 128'(err), 128'd1);
`else
        checkOutput("err_tied", 128'(err), 128'd0);
`endif
        checkOutput("orphan_no_rsp", 128'(rsp_valid), 128'd0);
        checkOutput("orphan_rsp_count", 128'(rsp_count), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
